// File: rtl/fifo_pkg.sv
// Shared constants and width helper for the single-clock FIFO.
// Optional occupancy output is enabled by defining FIFO_COUNT_EN.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 128;

    // Smallest r such that 2**r >= value; used for pointer and count widths.
    function automatic int log2_ceil(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: one write port, one registered read port.
// Storage is not reset; only the read register clears on rst.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_W     = log2_ceil(DEF_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register holds its value between accepted reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointer, occupancy and flag logic around fifo_mem.
// Define FIFO_COUNT_EN to expose the occupancy counter as output port count.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  wf_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full
`ifdef FIFO_COUNT_EN
    ,
    output logic [log2_ceil(DEPTH):0] count
`endif
);

    localparam int PTR_W = log2_ceil(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] occ;
    logic             wr_acc;
    logic             rd_acc;

    // Reset wins over every request; full blocks writes and empty blocks
    // reads even when the opposite port would free or fill a slot this cycle.
    assign wr_acc = !rst && enable && wf_en && !full;
    assign rd_acc = !rst && enable && rd_en && !empty;

    assign empty = (occ == '0);
    assign full  = (occ == CNT_W'(DEPTH));

`ifdef FIFO_COUNT_EN
    assign count = occ;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_acc) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (wptr),
        .wr_data (data_in),
        .rd_en   (rd_acc),
        .rd_addr (rptr),
        .rd_data (data_out)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed vector table, hand sequences
// for full/wrap/simultaneous/reset corners, and randomized traffic vs a queue model.
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 128;

    logic          clk;
    logic          rst;
    logic          enable;
    logic          wf_en;
    logic          rd_en;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          empty;
    logic          full;
`ifdef FIFO_COUNT_EN
    logic [7:0]    count;
`endif

    int checks;
    int failures;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_dout;

    sync_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .wf_en    (wf_en),
        .rd_en    (rd_en),
        .data_in  (data_in),
        .data_out (data_out),
        .empty    (empty),
        .full     (full)
`ifdef FIFO_COUNT_EN
        ,
        .count    (count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the reference model, compare outputs.
    task automatic step(input logic r, input logic e, input logic w, input logic rd,
                        input logic [DW-1:0] d);
        bit wa;
        bit ra;
        rst = r; enable = e; wf_en = w; rd_en = rd; data_in = d;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_dout = '0;
        end else begin
            wa = e && w && (mq.size() < DEPTH);
            ra = e && rd && (mq.size() > 0);
            if (ra) m_dout = mq.pop_front();
            if (wa) mq.push_back(d);
        end
        #1;
        check("model_data_out", 32'(data_out), 32'(m_dout));
        check("model_empty", 32'(empty), 32'(mq.size() == 0));
        check("model_full", 32'(full), 32'(mq.size() == DEPTH));
`ifdef FIFO_COUNT_EN
        check("model_count", 32'(count), 32'(mq.size()));
`endif
    endtask

    typedef struct {
        logic          r;
        logic          e;
        logic          w;
        logic          rd;
        logic [DW-1:0] din;
        logic [DW-1:0] dout;
        logic          emp;
        logic          ful;
    } vec_t;

    vec_t vecs[14];

    initial begin
        checks = 0; failures = 0;
        m_dout = '0;
        rst = 1'b0; enable = 1'b1; wf_en = 1'b0; rd_en = 1'b0; data_in = '0;

        // reset, order, interleave, enable-low: expected outputs after each edge
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'hA1, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'hB2, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'hC3, 8'h00, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'hA1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'hB2, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'hD4, 8'hB2, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'hE5, 8'hB2, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'hC3, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'hD4, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'hE5, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'hE5, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h77, 8'hE5, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hE5, 1'b1, 1'b0};

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].r, vecs[i].e, vecs[i].w, vecs[i].rd, vecs[i].din);
            check($sformatf("vec%0d_data_out", i), 32'(data_out), 32'(vecs[i].dout));
            check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].emp));
            check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].ful));
        end

        // Full, overflow drop, drain in order
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b1, 1'b0, DW'(i));
        check("full_after_128", 32'(full), 32'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'hFF);
        check("full_after_drop", 32'(full), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
            check($sformatf("drain_%0d", i), 32'(data_out), 32'(i));
        end
        check("empty_after_drain", 32'(empty), 32'd1);
        check("drain_no_ff", 32'(data_out), 32'h7F);

        // Cross the pointer wrap a second time with a partially full FIFO
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b1, 1'b0, DW'(8'h80 + i));
        for (int i = 0; i < 60; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        check("wrap_mid_data", 32'(data_out), 32'(8'h80 + 59));
        for (int i = 0; i < 60; i++) step(1'b0, 1'b1, 1'b1, 1'b0, DW'(i + 8'h10));
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        check("wrap_last_data", 32'(data_out), 32'(8'h10 + 59));
        check("wrap_empty", 32'(empty), 32'd1);

        // Simultaneous read and write with 5 stored keeps occupancy at 5
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, DW'(8'h50 + i));
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1, DW'(8'h60 + i));
            check($sformatf("simul_%0d_data", i),
                  32'(data_out), (i < 5) ? 32'(8'h50 + i) : 32'(8'h60 + i - 5));
            check($sformatf("simul_%0d_occ", i), 32'(mq.size()), 32'd5);
        end
        // enable low: nothing moves
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'hEE);
        check("en_low_data", 32'(data_out), 32'h64);
        check("en_low_empty", 32'(empty), 32'd0);

        // Mid-operation reset with a concurrent read
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, DW'(8'h31 + i));
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
        check("midrst_data", 32'(data_out), 32'd0);
        check("midrst_empty", 32'(empty), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        check("midrst_read_after", 32'(data_out), 32'd0);
        check("midrst_empty_after", 32'(empty), 32'd1);

        // Randomized traffic with phase-varying write/read bias
        for (int blk = 0; blk < 16; blk++) begin
            int wbias;
            int rbias;
            wbias = $urandom_range(10, 95);
            rbias = $urandom_range(10, 95);
            for (int c = 0; c < 200; c++) begin
                step(($urandom_range(0, 299) == 0),
                     ($urandom_range(0, 9) != 0),
                     ($urandom_range(0, 99) < wbias),
                     ($urandom_range(0, 99) < rbias),
                     DW'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
